// File: rtl/giris_toplayici_if.sv
// Byte-stream side and AES-core side of the block packer, grouped as one bundle.
// master drives bytes/key/hazir; slave (the packer) drives blocks toward the core.
interface giris_toplayici_if #(
    parameter int SAYAC_W = 2
);
    logic [7:0]         bayt;
    logic               bayt_gecerli;
    logic               bayt_hazir;
    logic               iptal;
    logic [127:0]       anahtar_in;
    logic               anahtar_yukle;
    logic               hazir;
    logic [127:0]       blok;
    logic [127:0]       anahtar;
    logic               g_gecerli;
    logic [SAYAC_W-1:0] adet;

    modport master (
        output bayt, bayt_gecerli, iptal, anahtar_in, anahtar_yukle, hazir,
        input  bayt_hazir, blok, anahtar, g_gecerli, adet
    );

    modport slave (
        input  bayt, bayt_gecerli, iptal, anahtar_in, anahtar_yukle, hazir,
        output bayt_hazir, blok, anahtar, g_gecerli, adet
    );
endinterface

// File: rtl/giris_toplayici.sv
// Packs bytes into 128-bit blocks tagged with the current key and queues them for the AES core;
// block valid one cycle after its 16th byte; only the 16th byte stalls, while the block FIFO is full.
module giris_toplayici #(
    parameter int DERINLIK = 2,
    parameter int SAYAC_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    giris_toplayici_if.slave  bus
);
    localparam int PW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;

    logic [3:0]         cnt_q, cnt_d;
    logic [119:0]       sr_q, sr_d;
    logic [127:0]       key_q, key_d;
    logic [SAYAC_W-1:0] adet_q, adet_d;
    logic [PW-1:0]      wptr_q, rptr_q;
    logic [127:0]       blk_mem_q [DERINLIK];
    logic [127:0]       key_mem_q [DERINLIK];
    logic [127:0]       blk_hold_q, key_hold_q;

    logic               full, acc, push, pop, nonempty;
    logic [127:0]       blk_new;

    assign full     = (adet_q == SAYAC_W'(DERINLIK));
    assign nonempty = (adet_q != '0);
    // Ready depends on registered state only; a pop in the same cycle does not free the slot early.
    assign bus.bayt_hazir = (cnt_q != 4'd15) || !full;
    assign acc      = bus.bayt_gecerli && bus.bayt_hazir && !bus.iptal;
    assign push     = acc && (cnt_q == 4'd15);
    assign pop      = nonempty && bus.hazir;
    assign blk_new  = {sr_q, bus.bayt};

    always_comb begin
        cnt_d  = cnt_q;
        sr_d   = sr_q;
        key_d  = key_q;
        adet_d = adet_q;
        if (bus.iptal) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (acc) begin
            cnt_d = cnt_q + 4'd1;
            sr_d  = {sr_q[111:0], bus.bayt};
        end
        if (bus.anahtar_yukle) begin
            key_d = bus.anahtar_in;
        end
        case ({push, pop})
            2'b10:   adet_d = adet_q + SAYAC_W'(1);
            2'b01:   adet_d = adet_q - SAYAC_W'(1);
            default: adet_d = adet_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            sr_q       <= '0;
            key_q      <= '0;
            adet_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            blk_hold_q <= '0;
            key_hold_q <= '0;
            for (int i = 0; i < DERINLIK; i++) begin
                blk_mem_q[i] <= '0;
                key_mem_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
            key_q  <= key_d;
            adet_q <= adet_d;
            // The pushed entry carries the key from before this edge, even if a load coincides.
            if (push) begin
                blk_mem_q[wptr_q] <= blk_new;
                key_mem_q[wptr_q] <= key_q;
                wptr_q            <= wptr_q + PW'(1);
            end
            if (pop) begin
                blk_hold_q <= blk_mem_q[rptr_q];
                key_hold_q <= key_mem_q[rptr_q];
                rptr_q     <= rptr_q + PW'(1);
            end
        end
    end

    assign bus.g_gecerli = nonempty;
    assign bus.adet      = adet_q;
    assign bus.blok      = nonempty ? blk_mem_q[rptr_q] : blk_hold_q;
    assign bus.anahtar   = nonempty ? key_mem_q[rptr_q] : key_hold_q;
endmodule

// File: doc/giris_toplayici.md
Name: giris_toplayici

Overview:
Upstream feeder for the AES-128 encryption core (ana_modul). It packs an 8-bit byte stream into 128-bit plaintext blocks and tags each block with the key current at completion. Completed blocks go through a small block FIFO and are presented to the core on its blok/anahtar/g_gecerli inputs, honouring the core's hazir handshake. The byte source can keep streaming while the core is busy.

Parameters:
DERINLIK, 2, number of {block,key} FIFO entries (power of two, >=2)
SAYAC_W, 2, width of the adet occupancy output; must hold 0..DERINLIK (DERINLIK=2 -> 2 bits)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
bayt  in  8  input byte
bayt_gecerli  in  1  bayt is valid this cycle
bayt_hazir  out  1  block is able to accept bayt this cycle
iptal  in  1  discard the partially assembled block
anahtar_in  in  128  new key value
anahtar_yukle  in  1  load anahtar_in into the key register
hazir  in  1  core ready, from ana_modul
blok  out  128  FIFO head plaintext, to ana_modul
anahtar  out  128  FIFO head key, to ana_modul
g_gecerli  out  1  FIFO non-empty, blok/anahtar valid
adet  out  SAYAC_W  number of full blocks held in FIFO

Behaviour:
- Reset (rst=0, async): byte counter=0, shift register=0, key register=0, FIFO empty (adet=0), g_gecerli=0, blok=0, anahtar=0. bayt_hazir=1 while in reset and after release. Reset mid-block or mid-FIFO discards everything, and no g_gecerli pulse is produced.
- Byte acceptance: a byte is accepted when bayt_gecerli=1 and bayt_hazir=1. The first byte of a block lands in bits [127:120] and the 16th in [7:0] (FIPS-197 byte order). The counter runs 0..15 and wraps to 0 on the 16th accepted byte.
- bayt_hazir = (counter != 15) || (adet < DERINLIK). It is registered-state only, with no same-cycle pop bypass. Bytes 1..15 are always accepted. The 16th byte stalls while the FIFO is full.
- Push: on the edge that accepts the 16th byte, {assembled block, key register value before that edge} is written to the FIFO tail.
- Key load: on anahtar_yukle=1 the key register takes anahtar_in at the edge. If anahtar_yukle coincides with a 16th byte, the pushed block carries the OLD key and the new key applies to subsequent blocks. Entries already in the FIFO keep their captured key.
- Output: g_gecerli = (adet != 0). blok/anahtar show the head entry and stay stable while g_gecerli=1 and hazir=0. When g_gecerli=0, blok/anahtar hold their last values and must not be used.
- Pop: the transfer happens on an edge where g_gecerli=1 and hazir=1, and the head advances.
- Latency: a 16th byte accepted at edge N into an empty FIFO gives g_gecerli=1 in the cycle after edge N. Zero bubble between back-to-back FIFO entries.
- Simultaneous push and pop: adet is unchanged, and this is legal when full only if the push was already allowed (bayt_hazir computed pre-pop).
- Wrap-around: read and write pointers wrap modulo DERINLIK. adet ranges 0..DERINLIK, with no overflow or underflow possible by construction.
- iptal=1: counter and shift register clear at the edge. A byte presented in the same cycle is dropped, even though the handshake showed accepted. The FIFO and key register are unaffected.

Test Plan:
- Reset, key load 2b7e1516_28aed2a6_abf71588_09cf4f3c, stream bytes 32,43,f6,...,07,34 with hazir=1 -> one cycle after the 16th byte: g_gecerli=1, blok=3243f6a8_885a308d_313198a2_e0370734, anahtar=2b7e..4f3c; g_gecerli=0 the next cycle.
- hazir=0, stream 3 blocks back-to-back (DERINLIK=2) -> adet reaches 2; bayt_hazir drops only at counter=15 of block 3; blok holds block 1; raise hazir -> blocks 1,2,3 emitted in order, with no byte lost.
- Load key 5468617473206D79204B756E67204675 on the same cycle as the 16th byte of block A, then stream block B -> A carries the previous key and B carries 5468..4675.
- Assert iptal after 7 bytes, then stream 16 bytes 54776F20..54776F -> exactly one block 54776F204F6E65204E696E652054776F; the 7 aborted bytes never appear.
- Pull rst low with adet=1 and counter=9 -> g_gecerli, adet and counter go 0 immediately (asynchronously); after release the first 16 bytes form the first block.
- Full FIFO, 16th byte waiting, hazir pulses 1 cycle -> pop on that edge; bayt_hazir=1 the next cycle; push occurs; adet returns to 2.
